// File: rtl/block_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller in front of a
// block memory. Lines live in registers; misses evict dirty victims and
// refill through the block interface; hit/miss counters feed the debug path.
module block_cache_ctrl #(
   parameter int unsigned DATA_WIDTH         = 32,
   parameter int unsigned ADDR_WIDTH         = 10,
   parameter int unsigned BLOCK_OFFSET_WIDTH = 3,
   parameter int unsigned INDEX_WIDTH        = 3
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [ADDR_WIDTH-1:0]                      cpu_addr,
   input  logic                                       cpu_re,
   input  logic                                       cpu_we,
   input  logic [DATA_WIDTH-1:0]                      cpu_din,
   output logic [DATA_WIDTH-1:0]                      cpu_dout,
   output logic                                       cpu_ready,
   output logic [ADDR_WIDTH-1:0]                      mem_addr,
   output logic                                       mem_we,
   output logic [(DATA_WIDTH<<BLOCK_OFFSET_WIDTH)-1:0] mem_block_din,
   input  logic [(DATA_WIDTH<<BLOCK_OFFSET_WIDTH)-1:0] mem_block_dout,
   input  logic                                       mem_block_valid,
   output logic [15:0]                                hit_count,
   output logic [15:0]                                miss_count
);

   localparam int unsigned BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH;
   localparam int unsigned NUM_LINES  = 1 << INDEX_WIDTH;
   localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
   localparam int unsigned LINE_WIDTH = DATA_WIDTH * BLOCK_SIZE;
   localparam int unsigned BLK_WIDTH  = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WRITEBACK = 2'd1;
   localparam logic [1:0] S_REFILL    = 2'd2;
   localparam logic [1:0] S_RESPOND   = 2'd3;

   logic [1:0]            state, state_nxt;

   logic [DATA_WIDTH-1:0] line_data [NUM_LINES][BLOCK_SIZE];
   logic [TAG_WIDTH-1:0]  line_tag  [NUM_LINES];
   logic [NUM_LINES-1:0]  line_valid;
   logic [NUM_LINES-1:0]  line_dirty;

   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_din;
   logic                  lat_we;
   logic                  first_cyc;

   logic [TAG_WIDTH-1:0]          req_tag_c, lat_tag_c;
   logic [INDEX_WIDTH-1:0]        req_idx_c, lat_idx_c, acc_idx_c;
   logic [BLOCK_OFFSET_WIDTH-1:0] req_off_c, lat_off_c, acc_off_c;
   logic                          req_c, hit_c, mem_done_c;
   logic                          do_hit_c, do_miss_c;
   logic                          acc_en_c, acc_we_c;
   logic [DATA_WIDTH-1:0]         acc_din_c;
   logic [ADDR_WIDTH-1:0]         rf_addr_c, wb_addr_c;
   logic [LINE_WIDTH-1:0]         victim_line_c;

   // Address fields of the live request and of the latched miss request
   always_comb begin
      req_tag_c = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
      req_idx_c = cpu_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
      req_off_c = cpu_addr[BLOCK_OFFSET_WIDTH-1:0];
      lat_tag_c = lat_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
      lat_idx_c = lat_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
      lat_off_c = lat_addr[BLOCK_OFFSET_WIDTH-1:0];
   end

   // Lookup, memory completion qualification and block addresses
   always_comb begin
      // while cpu_ready is high the CPU still holds the finished request
      req_c      = (cpu_re | cpu_we) & ~cpu_ready;
      hit_c      = line_valid[req_idx_c] && (line_tag[req_idx_c] == req_tag_c);
      // a valid left over from the previous transaction shows in the entry cycle
      mem_done_c = mem_block_valid & ~first_cyc;
      wb_addr_c  = {line_tag[req_idx_c], req_idx_c, {BLOCK_OFFSET_WIDTH{1'b0}}};
      if (state == S_IDLE) begin
         rf_addr_c = {cpu_addr[ADDR_WIDTH-1 -: BLK_WIDTH], {BLOCK_OFFSET_WIDTH{1'b0}}};
      end else begin
         rf_addr_c = {lat_addr[ADDR_WIDTH-1 -: BLK_WIDTH], {BLOCK_OFFSET_WIDTH{1'b0}}};
      end
   end

   // Victim line packed for the block write, word 0 in the low bits
   always_comb begin
      victim_line_c = '0;
      for (int unsigned w = 0; w < BLOCK_SIZE; w++) begin
         victim_line_c[w*DATA_WIDTH +: DATA_WIDTH] = line_data[req_idx_c][BLOCK_OFFSET_WIDTH'(w)];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and access selection
   always_comb begin
      state_nxt = state;
      do_hit_c  = 1'b0;
      do_miss_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_c) begin
               if (hit_c) begin
                  do_hit_c = 1'b1;
               end else begin
                  do_miss_c = 1'b1;
                  state_nxt = (line_valid[req_idx_c] && line_dirty[req_idx_c]) ? S_WRITEBACK
                                                                                : S_REFILL;
               end
            end
         end
         S_WRITEBACK: if (mem_done_c) state_nxt = S_REFILL;
         S_REFILL:    if (mem_done_c) state_nxt = S_RESPOND;
         S_RESPOND:   state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase

      acc_en_c = do_hit_c | (state == S_RESPOND);
      if (state == S_RESPOND) begin
         acc_idx_c = lat_idx_c;
         acc_off_c = lat_off_c;
         acc_we_c  = lat_we;
         acc_din_c = lat_din;
      end else begin
         acc_idx_c = req_idx_c;
         acc_off_c = req_off_c;
         acc_we_c  = cpu_we;
         acc_din_c = cpu_din;
      end
   end

   // CPU response, counters, miss latch, memory port and line tags/flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_ready     <= 1'b0;
         cpu_dout      <= '0;
         hit_count     <= '0;
         miss_count    <= '0;
         lat_addr      <= '0;
         lat_din       <= '0;
         lat_we        <= 1'b0;
         first_cyc     <= 1'b0;
         mem_addr      <= '0;
         mem_we        <= 1'b0;
         mem_block_din <= '0;
         line_valid    <= '0;
         line_dirty    <= '0;
         for (int unsigned i = 0; i < NUM_LINES; i++) begin
            line_tag[i] <= '0;
         end
      end else begin
         cpu_ready <= acc_en_c;
         if (acc_en_c && !acc_we_c) begin
            cpu_dout <= line_data[acc_idx_c][acc_off_c];
         end
         if (do_hit_c && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
         end
         if (do_miss_c) begin
            if (miss_count != 16'hFFFF) begin
               miss_count <= miss_count + 16'd1;
            end
            lat_addr <= cpu_addr;
            lat_din  <= cpu_din;
            lat_we   <= cpu_we;
         end

         first_cyc <= (state_nxt != state) &&
                      ((state_nxt == S_WRITEBACK) || (state_nxt == S_REFILL));

         // memory port moves only on the edge that enters a transaction
         if ((state == S_IDLE) && (state_nxt == S_WRITEBACK)) begin
            mem_addr      <= wb_addr_c;
            mem_we        <= 1'b1;
            mem_block_din <= victim_line_c;
         end else if ((state_nxt == S_REFILL) && (state != S_REFILL)) begin
            mem_addr <= rf_addr_c;
            mem_we   <= 1'b0;
         end

         if ((state == S_REFILL) && mem_done_c) begin
            line_valid[lat_idx_c] <= 1'b1;
            line_dirty[lat_idx_c] <= 1'b0;
            line_tag[lat_idx_c]   <= lat_tag_c;
         end else if (acc_en_c && acc_we_c) begin
            line_dirty[acc_idx_c] <= 1'b1;
         end
      end
   end

   // Line data: refill loads the whole line, writes update one word
   always_ff @(posedge clk) begin
      if ((state == S_REFILL) && mem_done_c) begin
         for (int unsigned w = 0; w < BLOCK_SIZE; w++) begin
            line_data[lat_idx_c][BLOCK_OFFSET_WIDTH'(w)] <= mem_block_dout[w*DATA_WIDTH +: DATA_WIDTH];
         end
      end else if (acc_en_c && acc_we_c) begin
         line_data[acc_idx_c][acc_off_c] <= acc_din_c;
      end
   end

endmodule
